ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, 64, datapath width in bits (32 or 64).
REQ-002 Parameter PC_STEP, 4, sequential PC increment.
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  in  1  upstream operation valid.
REQ-006 Port in_ready  out  1  stage can accept an operation this cycle.
REQ-007 Port alu_op  in  4  ALU operation code (ex_pkg encoding).
REQ-008 Port br_cond  in  3  branch condition, RISC-V funct3 encoding.
REQ-009 Port branch  in  1  operation is a conditional branch.
REQ-010 Port use_imm  in  1  ALU operand b = imm instead of rd2.
REQ-011 Port rd1, rd2, imm, pc  in  XLEN each  register operands, immediate, instruction PC.
REQ-012 Port out_valid  out  1  result registers valid.
REQ-013 Port out_ready  in  1  downstream accepts result.
REQ-014 Port alu_result, next_pc  out  XLEN each  registered ALU result, registered next PC.
REQ-015 Port branch_taken  out  1  registered branch decision.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready at a rising edge; operands captured that edge.
REQ-017 FSM states SHALL be IDLE, MUL, VALID; in_ready = (IDLE) || (VALID && out_ready); in_ready = 0 in MUL.
REQ-018 Single-cycle ops SHALL go IDLE/VALID -> VALID with out_valid = 1 one cycle after accept; back-to-back accepts give one result per cycle.
REQ-019 VALID && out_ready && !accept SHALL go to IDLE, out_valid = 0.
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-021 ALU ops: 0000 ADD, 1000 SUB, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND, 1010 MUL; any other code yields 0.
REQ-022 Arithmetic SHALL wrap modulo 2^XLEN; shift amount = low log2(XLEN) bits of operand b.
REQ-023 Branch compare SHALL use rd1 vs rd2 (never use_imm): 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 never taken.
REQ-024 branch_taken = branch && condition true; next_pc = taken ? pc + (imm << 1) : pc + PC_STEP, both wrapping modulo 2^XLEN.
REQ-025 alu_result for branches SHALL be the ALU result of alu_op on rd1/rd2 (don't-care to consumers, but deterministic).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, branch_taken 0, alu_result 0, next_pc 0, multiplier accumulator 0.
REQ-027 Reset mid-MUL SHALL abort the operation; no result is produced after release.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro EX_STAGE_MUL_EN defined: MUL (1010) SHALL use an iterative radix-2 shift-add unit, state MUL for exactly XLEN cycles, out_valid XLEN+1 cycles after accept, result = low XLEN bits of rd1*operand b (unsigned).
REQ-030 Macro undefined: no MUL state or multiplier logic; 1010 is undefined, result 0, single-cycle.

Structure
REQ-031 Package ex_pkg SHALL hold alu_op encodings, br_cond encodings, FSM state typedef, default PC_STEP.
REQ-032 Combinational ALU SHALL be sub-module ex_alu (XLEN-parametrised); FSM, branch unit, multiplier, output registers reside in ex_stage.

Verification (XLEN=64)
REQ-033 ADD rd1=5, rd2=7, pc=0x100, out_ready=1 -> next cycle out_valid=1, alu_result=12, next_pc=0x104, branch_taken=0.
REQ-034 branch=1, br_cond=100, rd1=-1, rd2=1, pc=0x100, imm=0x10 -> taken, next_pc=0x120; same with br_cond=110 -> not taken, next_pc=0x104.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no accept; out_ready=1 -> new op accepted same edge.
REQ-036 MUL 0xFFFF_FFFF*3: with EX_STAGE_MUL_EN -> alu_result 0x2_FFFF_FFFD, out_valid 65 cycles after accept; without -> 0 after 1 cycle.
REQ-037 rst_n low 10 cycles into MUL -> out_valid 0 at once, in_ready 1 after release, no stale result.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC, not taken -> next_pc=0; SRA rd1=0x8000_0000_0000_0000, rd2=0x43 -> 0xF000_0000_0000_0000.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALU ops, branch conditions, FSM states).
package ex_pkg;

  localparam int PC_STEP_DEF = 4;

  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b1000;
  localparam alu_op_t ALU_SLL  = 4'b0001;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SRA  = 4'b1101;
  localparam alu_op_t ALU_SLT  = 4'b0010;
  localparam alu_op_t ALU_SLTU = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_OR   = 4'b0110;
  localparam alu_op_t ALU_AND  = 4'b0111;
  localparam alu_op_t ALU_MUL  = 4'b1010;

  typedef logic [2:0] br_cond_t;
  localparam br_cond_t BR_EQ  = 3'b000;
  localparam br_cond_t BR_NE  = 3'b001;
  localparam br_cond_t BR_LT  = 3'b100;
  localparam br_cond_t BR_GE  = 3'b101;
  localparam br_cond_t BR_LTU = 3'b110;
  localparam br_cond_t BR_GEU = 3'b111;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: upstream operation handshake plus downstream result handshake of the execute stage.
interface ex_stage_if
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  alu_op_t         alu_op;
  br_cond_t        br_cond;
  logic            branch;
  logic            use_imm;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] next_pc;
  logic            branch_taken;

  modport master (
    output in_valid, alu_op, br_cond, branch, use_imm, rd1, rd2, imm, pc, out_ready,
    input  in_ready, out_valid, alu_result, next_pc, branch_taken
  );

  modport slave (
    input  in_valid, alu_op, br_cond, branch, use_imm, rd1, rd2, imm, pc, out_ready,
    output in_ready, out_valid, alu_result, next_pc, branch_taken
  );
endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational XLEN-wide integer ALU; unknown codes (including MUL) produce zero.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: registered execute stage (ALU, branch resolution, next PC) with valid/ready handshakes.
// Defining EX_STAGE_MUL_EN adds an iterative radix-2 shift-add multiplier for op 1010.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  state_t          state;
  logic            accept;
  logic            mul_op;
  logic            cond_true;
  logic            taken;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc_seq;

  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_VALID) && bus.out_ready);
  assign bus.out_valid = (state == ST_VALID);
  assign accept        = bus.in_valid && bus.in_ready;

  // Branches always compare and compute on the register pair, never the immediate.
  assign op_b = (bus.use_imm && !bus.branch) ? bus.imm : bus.rd2;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .op (bus.alu_op),
    .a  (bus.rd1),
    .b  (op_b),
    .y  (alu_y)
  );

  always_comb begin
    cond_true = 1'b0;
    case (bus.br_cond)
      BR_EQ:   cond_true = (bus.rd1 == bus.rd2);
      BR_NE:   cond_true = (bus.rd1 != bus.rd2);
      BR_LT:   cond_true = ($signed(bus.rd1) < $signed(bus.rd2));
      BR_GE:   cond_true = ($signed(bus.rd1) >= $signed(bus.rd2));
      BR_LTU:  cond_true = (bus.rd1 < bus.rd2);
      BR_GEU:  cond_true = (bus.rd1 >= bus.rd2);
      default: cond_true = 1'b0;
    endcase
  end

  assign taken     = bus.branch && cond_true;
  assign pc_target = bus.pc + (bus.imm << 1);
  assign pc_seq    = bus.pc + XLEN'(PC_STEP);

`ifdef EX_STAGE_MUL_EN
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [CW-1:0]   mcnt;
  logic            mul_last;

  assign mul_op   = (bus.alu_op == ALU_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state == ST_MUL) && (mcnt == CW'(XLEN - 1));

  // One multiplier bit per cycle; XLEN iterations after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mcnt <= '0;
    end else if (accept && mul_op) begin
      acc  <= '0;
      mcnt <= '0;
    end else if (state == ST_MUL) begin
      acc  <= acc_next;
      mcnt <= mcnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && mul_op) begin
      mcand  <= bus.rd1;
      mplier <= op_b;
    end else if (state == ST_MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign mul_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_VALID: begin
          if (accept)
            state <= mul_op ? ST_MUL : ST_VALID;
          else if ((state == ST_VALID) && bus.out_ready)
            state <= ST_IDLE;
        end
`ifdef EX_STAGE_MUL_EN
        ST_MUL: if (mul_last) state <= ST_VALID;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output registers: loaded on accept, held otherwise (stall keeps them stable).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_result   <= '0;
      bus.next_pc      <= '0;
      bus.branch_taken <= 1'b0;
    end else if (accept) begin
      bus.alu_result   <= alu_y;
      bus.next_pc      <= taken ? pc_target : pc_seq;
      bus.branch_taken <= taken;
    end
`ifdef EX_STAGE_MUL_EN
    else if (mul_last) begin
      bus.alu_result   <= acc_next;
    end
`endif
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (XLEN=64) with a behavioural reference model.
module tb_ex_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(XLEN)) bus ();

  ex_stage #(.XLEN(XLEN), .PC_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] alu;
    logic [63:0] npc;
    logic        taken;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h required %h", name, act, req);
    else passes++;
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [2:0] c, input logic br,
                                 input logic ui, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] im, input logic [63:0] p);
    exp_t e;
    logic [63:0] ob;
    logic [63:0] ones;
    int s;
    logic cond;
    ones = '1;
    ob = (ui && !br) ? im : b;
    s = int'(ob[5:0]);
    e.lat = 0;
    e.acc = 0;
    case (op)
      4'b0000: e.alu = a + ob;
      4'b1000: e.alu = a - ob;
      4'b0001: e.alu = a << s;
      4'b0101: e.alu = a >> s;
      4'b1101: e.alu = (a >> s) | (a[63] ? ~(ones >> s) : 64'd0);
      4'b0010: e.alu = ($signed(a) < $signed(ob)) ? 64'd1 : 64'd0;
      4'b0011: e.alu = (a < ob) ? 64'd1 : 64'd0;
      4'b0100: e.alu = a ^ ob;
      4'b0110: e.alu = a | ob;
      4'b0111: e.alu = a & ob;
`ifdef EX_STAGE_MUL_EN
      4'b1010: begin e.alu = a * ob; e.lat = XLEN; end
`endif
      default: e.alu = 64'd0;
    endcase
    case (c)
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = ($signed(a) < $signed(b));
      3'b101:  cond = ($signed(a) >= $signed(b));
      3'b110:  cond = (a < b);
      3'b111:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
    e.taken = br && cond;
    e.npc = e.taken ? p + (im << 1) : p + 64'd4;
    return e;
  endfunction

  // Monitor: latency on first presentation, payload on handshake, stability while stalled.
  initial begin : monitor
    exp_t e;
    logic held = 1'b0;
    logic new_item = 1'b1;
    logic [63:0] h_alu, h_npc;
    logic h_tk;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
        new_item = 1'b1;
      end else begin
        if (held) begin
          chk("hold_out_valid", bus.out_valid, 1'b1);
          if (bus.out_valid) begin
            chk("hold_alu_result", bus.alu_result, h_alu);
            chk("hold_next_pc", bus.next_pc, h_npc);
            chk("hold_branch_taken", bus.branch_taken, h_tk);
          end
        end
        held = 1'b0;
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("no_pending_out_valid", bus.out_valid, 1'b0);
          end else begin
            if (new_item) begin
              chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
              new_item = 1'b0;
            end
            if (bus.out_ready) begin
              e = q.pop_front();
              chk("alu_result", bus.alu_result, e.alu);
              chk("next_pc", bus.next_pc, e.npc);
              chk("branch_taken", bus.branch_taken, e.taken);
              new_item = 1'b1;
            end else begin
              held = 1'b1;
              h_alu = bus.alu_result;
              h_npc = bus.next_pc;
              h_tk = bus.branch_taken;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] c, input logic br, input logic ui,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic [63:0] p, input bit rnd_ready, output int tries);
    exp_t e;
    bit done = 1'b0;
    e = model(op, c, br, ui, a, b, im, p);
    tries = 0;
    while (!done && tries < 200) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_op = op;
      bus.br_cond = c;
      bus.branch = br;
      bus.use_imm = ui;
      bus.rd1 = a;
      bus.rd2 = b;
      bus.imm = im;
      bus.pc = p;
      bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tries++;
      #1;
      if (bus.in_ready) begin
        e.acc = cyc + 1;
        q.push_back(e);
        done = 1'b1;
        @(posedge clk);
      end
    end
    if (!done) chk("accept_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 2))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 15));
      default: return -64'($urandom_range(1, 16));
    endcase
  endfunction

  initial begin : driver
    int t;
    logic [3:0] codes [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101,
                               4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
    logic [3:0] op;
    logic [63:0] a;
    logic [63:0] b;
    int r;
    int waited;

    bus.in_valid = 1'b0; bus.alu_op = '0; bus.br_cond = '0; bus.branch = 1'b0;
    bus.use_imm = 1'b0; bus.rd1 = '0; bus.rd2 = '0; bus.imm = '0; bus.pc = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_alu_result", bus.alu_result, 64'd0);
    chk("rst_next_pc", bus.next_pc, 64'd0);
    chk("rst_branch_taken", bus.branch_taken, 1'b0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", bus.in_ready, 1'b1);

    issue(4'b0000, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 64'h100, 1'b0, t);
    issue(4'b0000, 3'b100, 1'b1, 1'b0, -64'd1, 64'd1, 64'h10, 64'h100, 1'b0, t);
    issue(4'b0000, 3'b110, 1'b1, 1'b0, -64'd1, 64'd1, 64'h10, 64'h100, 1'b0, t);
    issue(4'b1101, 3'b000, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h43, 64'd0, 64'd0, 1'b0, t);
    issue(4'b0000, 3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, t);
    issue(4'b0110, 3'b000, 1'b0, 1'b1, 64'hF0, 64'd0, 64'h0F, 64'h200, 1'b0, t);

    // Downstream stall with a waiting operation: no accept until out_ready returns.
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_op = 4'b1000; bus.branch = 1'b0; bus.use_imm = 1'b0;
      bus.rd1 = 64'd3; bus.rd2 = 64'd10; bus.pc = 64'h300;
      bus.out_ready = 1'b0;
      #1;
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_out_valid", bus.out_valid, 1'b1);
    end
    issue(4'b1000, 3'b000, 1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'h300, 1'b0, t);
    chk("stall_release_tries", 64'(t), 64'd1);

    issue(4'b1010, 3'b000, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd3, 64'd0, 64'h400, 1'b0, t);
    idle(2, 1'b0);

    // Reset in the middle of a multiply: nothing from it may surface afterwards.
    issue(4'b1010, 3'b000, 1'b0, 1'b0, 64'h1234_5678, 64'h9ABC, 64'd0, 64'h500, 1'b0, t);
    idle(10, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midmul_rst_out_valid", bus.out_valid, 1'b0);
    chk("midmul_rst_alu_result", bus.alu_result, 64'd0);
    idle(2, 1'b0);
    rst_n = 1'b1;
    #1 chk("midmul_release_in_ready", bus.in_ready, 1'b1);
    idle(80, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) op = 4'b1010;
      else if (r < 12) op = 4'($urandom);
      else op = codes[$urandom_range(0, 9)];
      a = rnd64();
      b = ($urandom_range(0, 3) == 0) ? a : rnd64();
      issue(op, 3'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), a, b, rnd64(), rnd64(),
            1'b1, t);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), 1'b1);
    end

    waited = 0;
    while (q.size() != 0 && waited < 300) begin
      idle(1, 1'b0);
      waited++;
    end
    idle(3, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
